// File: rtl/n64adv_vclk_cfg_latch.sv
// Purpose : brings the CPU-domain configuration into VCLK and applies it to the video
//           outputs only on a vertical-sync falling edge, so settings never change mid-frame.
// Latency : config input to resynced = SYNC_STAGES edges; VD_VSi fall to negedge_nVSYNC = 1
//           qualified sample; outputs update on the next nVDSYNC-low cycle.
// Backpressure: none; nVDSYNC acts as a qualifier only, and all outputs hold between latch events.
//
// Ports:
//   VCLK, nVRST                 video clock, async active-low reset
//   nVDSYNC, VD_VSi             data-sync qualifier and vsync level from the video stream
//   SysConfigSet2/1/0           CPU-domain config words (asynchronous to VCLK)
//   negedge_nVSYNC              registered vsync falling-edge flag
//   MANAGE_VPLL, OSDInfo,
//   use_igr, PPUConfigSet       frame-coherent configuration outputs
module n64adv_vclk_cfg_latch #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        VCLK,
    input  logic        nVRST,
    input  logic        nVDSYNC,
    input  logic        VD_VSi,
    input  logic [31:0] SysConfigSet2,
    input  logic [31:0] SysConfigSet1,
    input  logic [31:0] SysConfigSet0,
    output logic        negedge_nVSYNC,
    output logic [1:0]  MANAGE_VPLL,
    output logic [1:0]  OSDInfo,
    output logic        use_igr,
    output logic [68:0] PPUConfigSet
);

    // Resynchroniser: stage 0 samples the asynchronous words, the last stage is the usable copy.
    logic [SYNC_STAGES-1:0][95:0] sync_q, sync_d;

    logic        nvsync_cur_q, nvsync_cur_d;
    logic        negedge_q, negedge_d;
    logic [1:0]  manage_vpll_q, manage_vpll_d;
    logic [1:0]  osd_info_q, osd_info_d;
    logic        use_igr_q, use_igr_d;
    logic [68:0] ppu_cfg_q, ppu_cfg_d;

    logic [31:0] cfg2, cfg1, cfg0;
    logic        latch_evt;
    logic        unused_cfg2_hi;

    assign {cfg2, cfg1, cfg0} = sync_q[SYNC_STAGES-1];
    // Bits 31:11 of word 2 carry no meaning in this domain.
    assign unused_cfg2_hi     = ^cfg2[31:11];

    // The edge flag is registered, so the latch happens one qualified sample after the fall;
    // in that same cycle the flag is recomputed from a low-low pair and drops, giving one latch per edge.
    assign latch_evt = ~nVDSYNC & negedge_q;

    always_comb begin
        sync_d[0] = {SysConfigSet2, SysConfigSet1, SysConfigSet0};
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    always_comb begin
        nvsync_cur_d = nvsync_cur_q;
        negedge_d    = negedge_q;
        if (!nVDSYNC) begin
            nvsync_cur_d = VD_VSi;
            negedge_d    = nvsync_cur_q & ~VD_VSi;
        end
    end

    always_comb begin
        manage_vpll_d = manage_vpll_q;
        osd_info_d    = osd_info_q;
        use_igr_d     = use_igr_q;
        ppu_cfg_d     = ppu_cfg_q;
        if (latch_evt) begin
            manage_vpll_d = {cfg2[1], cfg2[0]};
            // mute_osd overrides both the OSD and its logo.
            osd_info_d    = {cfg2[5] & cfg2[4] & ~cfg2[3], cfg2[4] & ~cfg2[3]};
            use_igr_d     = cfg2[2];
            ppu_cfg_d     = {cfg2[10], cfg2[9], cfg2[8:6], cfg1, cfg0};
        end
    end

    always_ff @(posedge VCLK or negedge nVRST) begin
        if (!nVRST) begin
            sync_q        <= '0;
            nvsync_cur_q  <= 1'b0;
            negedge_q     <= 1'b0;
            manage_vpll_q <= '0;
            osd_info_q    <= '0;
            use_igr_q     <= 1'b0;
            ppu_cfg_q     <= '0;
        end else begin
            sync_q        <= sync_d;
            nvsync_cur_q  <= nvsync_cur_d;
            negedge_q     <= negedge_d;
            manage_vpll_q <= manage_vpll_d;
            osd_info_q    <= osd_info_d;
            use_igr_q     <= use_igr_d;
            ppu_cfg_q     <= ppu_cfg_d;
        end
    end

    assign negedge_nVSYNC = negedge_q;
    assign MANAGE_VPLL    = manage_vpll_q;
    assign OSDInfo        = osd_info_q;
    assign use_igr        = use_igr_q;
    assign PPUConfigSet   = ppu_cfg_q;

endmodule

// File: tb/tb_n64adv_vclk_cfg_latch.sv
module tb_n64adv_vclk_cfg_latch;

    localparam int SYNC = 2;

    logic        VCLK = 1'b0;
    logic        nVRST = 1'b0;
    logic        nVDSYNC = 1'b1;
    logic        VD_VSi = 1'b1;
    logic [31:0] SysConfigSet2 = '1;
    logic [31:0] SysConfigSet1 = '1;
    logic [31:0] SysConfigSet0 = '1;
    logic        negedge_nVSYNC;
    logic [1:0]  MANAGE_VPLL;
    logic [1:0]  OSDInfo;
    logic        use_igr;
    logic [68:0] PPUConfigSet;

    n64adv_vclk_cfg_latch #(.SYNC_STAGES(SYNC)) dut (
        .VCLK          (VCLK),
        .nVRST         (nVRST),
        .nVDSYNC       (nVDSYNC),
        .VD_VSi        (VD_VSi),
        .SysConfigSet2 (SysConfigSet2),
        .SysConfigSet1 (SysConfigSet1),
        .SysConfigSet0 (SysConfigSet0),
        .negedge_nVSYNC(negedge_nVSYNC),
        .MANAGE_VPLL   (MANAGE_VPLL),
        .OSDInfo       (OSDInfo),
        .use_igr       (use_igr),
        .PPUConfigSet  (PPUConfigSet)
    );

    always #5 VCLK = ~VCLK;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [68:0] act, input logic [68:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a plain delay line of config words and a list of qualified vsync
    // samples since reset. A latch happens at the qualified sample following a (1,0) pair.
    typedef struct {
        logic        ne;
        logic [1:0]  mv;
        logic [1:0]  osd;
        logic        igr;
        logic [68:0] ppu;
    } exp_t;

    exp_t        sb[$];
    exp_t        cur = '{ne: 1'b0, mv: 2'b0, osd: 2'b0, igr: 1'b0, ppu: 69'b0};
    logic [95:0] hist[$];
    bit          qs[$];
    logic [95:0] rs;
    logic [31:0] c2;
    int          n, j;

    always @(posedge VCLK) begin
        if (!nVRST) begin
            hist.delete();
            qs.delete();
            cur = '{ne: 1'b0, mv: 2'b0, osd: 2'b0, igr: 1'b0, ppu: 69'b0};
        end else begin
            n  = hist.size();
            rs = (n >= SYNC) ? hist[n-SYNC] : 96'b0;
            hist.push_back({SysConfigSet2, SysConfigSet1, SysConfigSet0});
            if (!nVDSYNC) begin
                j = qs.size();
                if (j >= 2 && qs[j-2] && !qs[j-1]) begin
                    c2      = rs[95:64];
                    cur.mv  = c2[1:0];
                    cur.osd = {c2[5] && c2[4] && !c2[3], c2[4] && !c2[3]};
                    cur.igr = c2[2];
                    cur.ppu = {c2[10], c2[9], c2[8:6], rs[63:0]};
                end
                qs.push_back(VD_VSi);
                j = qs.size();
                cur.ne = (j >= 2) && qs[j-2] && !qs[j-1];
            end
        end
        sb.push_back(cur);
    end

    exp_t e;
    always @(posedge VCLK) begin
        #1;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_empty at %0t", $time);
        end else begin
            e = sb.pop_front();
            chk("sb_negedge", {68'b0, negedge_nVSYNC}, {68'b0, e.ne});
            chk("sb_vpll",    {67'b0, MANAGE_VPLL},    {67'b0, e.mv});
            chk("sb_osd",     {67'b0, OSDInfo},        {67'b0, e.osd});
            chk("sb_igr",     {68'b0, use_igr},        {68'b0, e.igr});
            chk("sb_ppu",     PPUConfigSet,            e.ppu);
        end
    end

    task automatic step(input logic nvd, input logic vs);
        @(negedge VCLK);
        nVDSYNC = nvd;
        VD_VSi  = vs;
    endtask

    task automatic vsync_pulse();
        for (int i = 0; i < 6; i++) step(i[0], 1'b1);
        for (int i = 0; i < 8; i++) step(i[0], 1'b0);
    endtask

    initial begin
        // Reset with all-ones config, then no vsync activity.
        repeat (4) step(1'b0, 1'b1);
        @(negedge VCLK);
        nVRST = 1'b1;
        for (int i = 0; i < 20; i++) step(i[0], 1'b1);
        chk("rst_negedge", {68'b0, negedge_nVSYNC}, 69'b0);
        chk("rst_vpll",    {67'b0, MANAGE_VPLL},    69'b0);
        chk("rst_osd",     {67'b0, OSDInfo},        69'b0);
        chk("rst_igr",     {68'b0, use_igr},        69'b0);
        chk("rst_ppu",     PPUConfigSet,            69'b0);

        // Basic latch.
        SysConfigSet2 = 32'h0000_07F7;
        SysConfigSet1 = 32'hA5A5_A5A5;
        SysConfigSet0 = 32'h1234_5678;
        vsync_pulse();
        chk("basic_vpll", {67'b0, MANAGE_VPLL}, 69'd3);
        chk("basic_osd",  {67'b0, OSDInfo},     69'd3);
        chk("basic_igr",  {68'b0, use_igr},     69'd1);
        chk("basic_ppu",  PPUConfigSet,         {2'b11, 3'b111, 32'hA5A5_A5A5, 32'h1234_5678});

        // Mute overrides OSD and logo; show_osd alone gives 01.
        SysConfigSet2 = 32'h0000_0038;
        vsync_pulse();
        chk("mute_osd", {67'b0, OSDInfo}, 69'd0);
        SysConfigSet2 = 32'h0000_0010;
        vsync_pulse();
        chk("showonly_osd", {67'b0, OSDInfo}, 69'd1);

        // Frame coherence: mid-frame change held until the next vsync fall.
        for (int i = 0; i < 4; i++) step(i[0], 1'b1);
        SysConfigSet0 = 32'hFFFF_0000;
        for (int i = 0; i < 10; i++) step(i[0], 1'b1);
        chk("coh_hold", {37'b0, PPUConfigSet[31:0]}, {37'b0, 32'h1234_5678});
        vsync_pulse();
        chk("coh_new", {37'b0, PPUConfigSet[31:0]}, {37'b0, 32'hFFFF_0000});

        // Qualifier: low only during an unqualified cycle is invisible.
        SysConfigSet2 = 32'h0000_07F7;
        for (int i = 0; i < 6; i++) step(i[0], 1'b1);
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        for (int i = 0; i < 6; i++) step(i[0], 1'b1);
        chk("qual_osd",     {67'b0, OSDInfo},        69'd1);
        chk("qual_negedge", {68'b0, negedge_nVSYNC}, 69'b0);

        // Sync latency: change sampled one edge before the latch edge is too late.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        SysConfigSet0 = 32'hCAFE_BABE;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk("lat_old", {37'b0, PPUConfigSet[31:0]}, {37'b0, 32'hFFFF_0000});
        chk("lat_osd", {67'b0, OSDInfo},            69'd3);
        vsync_pulse();
        chk("lat_new", {37'b0, PPUConfigSet[31:0]}, {37'b0, 32'hCAFE_BABE});

        // Randomised traffic with occasional mid-frame resets.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                SysConfigSet2 = $urandom;
                SysConfigSet1 = $urandom;
                SysConfigSet0 = $urandom;
            end
            if ($urandom_range(0, 399) == 0) begin
                @(negedge VCLK);
                nVRST = 1'b0;
                repeat (3) @(negedge VCLK);
                nVRST = 1'b1;
            end
            step(1'($urandom_range(0, 1)),
                 ($urandom_range(0, 9) == 0) ? ~VD_VSi : VD_VSi);
        end

        repeat (4) @(negedge VCLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/n64adv_vclk_cfg_latch.md
Name: n64adv_vclk_cfg_latch

Overview:
- VCLK-domain configuration front end of the N64 video pipeline.
- Resynchronises the 96-bit system configuration word from the CPU (25 MHz) domain into VCLK with a multi-flop chain.
- Detects the falling edge of vertical sync in the N64 video data stream and applies the resynced configuration to the video processing outputs only at that edge, so settings never change mid-frame.
- Exports the vsync-edge strobe for other blocks (controller sniffer, CPU sync).

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops per config bit (legal values 2..4).

Ports:
- VCLK  in  1  video clock; all logic on rising edge.
- nVRST  in  1  reset, asynchronous assert, active-low.
- nVDSYNC  in  1  active-low data-sync qualifier; VD_VSi is valid only in cycles with nVDSYNC = 0.
- VD_VSi  in  1  vertical sync level from the video data stream (1 = inactive).
- SysConfigSet2  in  32  CPU-domain config word 2, asynchronous to VCLK.
- SysConfigSet1  in  32  CPU-domain config word 1, asynchronous to VCLK.
- SysConfigSet0  in  32  CPU-domain config word 0, asynchronous to VCLK.
- negedge_nVSYNC  out  1  registered vsync falling-edge flag.
- MANAGE_VPLL  out  2  {use_vpll, test_vpll}.
- OSDInfo  out  2  [1] = show OSD logo, [0] = show OSD.
- use_igr  out  1  in-game-reset enable.
- PPUConfigSet  out  69  {show_testpattern, exchange_RB, FilterSet[2:0], SysConfigSet1, SysConfigSet0}.

Behaviour:
- SysConfigSet2 bit map (fixed):
  - [0] test_vpll
  - [1] use_vpll
  - [2] igr_reset_enable
  - [3] mute_osd
  - [4] show_osd
  - [5] show_osd_logo
  - [8:6] FilterSet
  - [9] exchange_RB
  - [10] show_testpattern
  - [31:11] ignored
- Resynchroniser:
  - Each of the 96 bits passes through SYNC_STAGES flops.
  - Flops are cleared to 0 asynchronously by nVRST.
  - Input-to-resynced latency = SYNC_STAGES VCLK edges.
- Vsync edge detect (reg nVSYNC_cur, reset 0; negedge_nVSYNC, reset 0):
  - Updates only in cycles with nVDSYNC = 0: nVSYNC_cur <= VD_VSi; negedge_nVSYNC <= nVSYNC_cur & ~VD_VSi.
  - In cycles with nVDSYNC = 1 both registers hold.
- Latch event: a cycle with nVDSYNC = 0 and negedge_nVSYNC = 1 (registered value). On that edge:
  - MANAGE_VPLL <= {cfg2[1], cfg2[0]}
  - OSDInfo[1] <= cfg2[5] & cfg2[4] & ~cfg2[3]
  - OSDInfo[0] <= cfg2[4] & ~cfg2[3]
  - use_igr <= cfg2[2]
  - PPUConfigSet <= {cfg2[10], cfg2[9], cfg2[8:6], cfg1, cfg0}
  - cfg* denotes the resynchronised words.
- Outside latch events all outputs hold their values.
- Exactly one latch per vsync falling edge: in the latch cycle negedge_nVSYNC is simultaneously recomputed and becomes 0 while VD_VSi stays low.
- Latency: VD_VSi low sampled in nVDSYNC-low cycle k raises negedge_nVSYNC after edge k; outputs update at the edge of the next nVDSYNC-low cycle.
- Config applied is the resynced value present in the latch cycle. A config change less than SYNC_STAGES cycles before the latch is applied at the following vsync.
- Reset:
  - All outputs, edge-detect registers and sync flops are 0 while nVRST = 0.
  - After release, outputs stay 0 until the first latch event.
  - Reset mid-frame discards any pending edge.
- VD_VSi constantly low or constantly high produces no latch events; outputs hold.

Test Plan:
- Reset: hold nVRST = 0 with SysConfigSet* = all ones, then release, no vsync -> all outputs 0 indefinitely; negedge_nVSYNC = 0.
- Basic latch:
  - Stimulus: cfg2 = 0x0000_07F7 (show_osd = 1, logo = 1, mute = 0, FilterSet = 7, RB = 1, TP = 1, use_vpll = 1, test_vpll = 1, igr = 1), cfg1 = 0xA5A5A5A5, cfg0 = 0x12345678; toggle nVDSYNC every cycle; drive VD_VSi 1 -> 0.
  - Required: negedge_nVSYNC pulses for one qualified sample; then MANAGE_VPLL = 2'b11, OSDInfo = 2'b11, use_igr = 1, PPUConfigSet = {1, 1, 3'b111, 0xA5A5A5A5, 0x12345678}.
- Mute: cfg2[3] = 1 with show_osd = 1, logo = 1 -> after next vsync edge OSDInfo = 2'b00; with cfg2 = show_osd only -> OSDInfo = 2'b01.
- Frame coherence: change cfg0 to 0xFFFF0000 mid-frame -> PPUConfigSet[31:0] keeps its old value until the next VD_VSi falling edge, then becomes 0xFFFF0000; no other update in between.
- Qualifier: VD_VSi falls only while nVDSYNC = 1, and returns high before any nVDSYNC = 0 cycle -> no edge detected, outputs unchanged.
- Sync latency: cfg change 1 cycle before a latch cycle (SYNC_STAGES = 2) -> old value latched; the new value appears only at the following vsync edge.
